// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, control states and flag layout.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_ANDN = 4'b0100,
    OP_ORN  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_NOR  = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_SLL  = 4'b1011,
    OP_SRL  = 4'b1100,
    OP_SRA  = 4'b1101,
    OP_ILL0 = 4'b1110,
    OP_ILL1 = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-add multiplier: one partial-product step per cycle, N steps.
// 'product' and 'done' describe the value produced by the step in progress, so the
// caller can register the final product on the same edge as the last step.
module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]   mcand;
  logic [2*N-1:0] acc;   // {partial high word, remaining multiplier bits}
  logic [CW-1:0]  cnt;
  logic [N:0]     sum;

  // One shift-add step: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  always_comb begin
    sum     = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
    product = {sum, acc[N-1:1]};
    done    = busy && (cnt == CW'(N - 1));
  end

  // Operand capture on start, then N iterations.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      acc   <= {{N{1'b0}}, b};
    end else if (busy) begin
      acc <= product;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Single-cycle ops register their
// result at accept; MUL runs N cycles in alu_mul_seq before the result is registered.
module alu_mc
  import alu_pkg::*;
#(
  parameter int N      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [N-1:0] hi,
  output logic [3:0]   flags,
  output logic         err
);

  localparam int SW = $clog2(N);

  alu_state_e     state, state_nxt;
  alu_op_e        op_e;
  alu_flags_t     flags_q, s_flags, m_flags;
  logic           accept, is_mul, sub;
  logic [N-1:0]   bx, diff, s_y;
  logic [N:0]     sum;
  logic           carry, ovf, s_c, s_v, s_err;
  logic [SW-1:0]  shamt;
  logic           mul_busy, mul_done;
  logic [2*N-1:0] mul_prod;

  assign op_e   = alu_op_e'(op);
  assign is_mul = MUL_EN && (op_e == OP_MUL);
  assign accept = in_valid && in_ready;
  assign shamt  = b[SW-1:0];

  // Shared N+1-bit adder: subtraction is a + ~b + 1, overflow when the operands
  // seen by the adder agree in sign and the result does not.
  always_comb begin
    sub   = (op_e == OP_SUB) || (op_e == OP_SLT) || (op_e == OP_SLTU);
    bx    = b ^ {N{sub}};
    sum   = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, sub};
    diff  = sum[N-1:0];
    carry = sum[N];
    ovf   = (a[N-1] == bx[N-1]) && (diff[N-1] != a[N-1]);
  end

  // Single-cycle result, C/V and illegal detection; MUL lands here only when disabled.
  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    s_y   = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_err = 1'b0;
    case (op_e)
      OP_AND:  s_y = a & b;
      OP_OR:   s_y = a | b;
      OP_ADD:  begin s_y = diff; s_c = carry; s_v = ovf; end
      OP_SUB:  begin s_y = diff; s_c = carry; s_v = ovf; end
      OP_SLT:  s_y = {{(N-1){1'b0}}, diff[N-1] ^ ovf};
      OP_SLTU: s_y = {{(N-1){1'b0}}, ~carry};
      OP_ANDN: s_y = a & ~b;
      OP_ORN:  s_y = a | ~b;
      OP_XOR:  s_y = a ^ b;
      OP_NOR:  s_y = ~(a | b);
      OP_SLL:  s_y = a << shamt;
      OP_SRL:  s_y = a >> shamt;
      OP_SRA:  s_y = $unsigned($signed(a) >>> shamt);
      default: s_err = 1'b1;
    endcase
    s_flags = s_err ? '0 : '{z: (s_y == '0), n: s_y[N-1], c: s_c, v: s_v};
    m_flags = '{z: (mul_prod[N-1:0] == '0), n: mul_prod[N-1],
                c: (mul_prod[2*N-1:N] != '0), v: 1'b0};
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.N(N)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs; DONE hands in_ready to the consumer so a new
  // op can be accepted on the edge the current result leaves.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (accept) state_nxt = is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (mul_done)      state_nxt = DONE;
        else if (!mul_busy) state_nxt = IDLE;  // multiplier lost its op; never wedge
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !reset;
        if (out_ready) begin
          if (accept) state_nxt = is_mul ? BUSY : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers: loaded at accept for single-cycle ops, on the last step for MUL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y       <= '0;
      hi      <= '0;
      flags_q <= '0;
      err     <= 1'b0;
    end else if (mul_done) begin
      y       <= mul_prod[N-1:0];
      hi      <= mul_prod[2*N-1:N];
      flags_q <= m_flags;
      err     <= 1'b0;
    end else if (accept && !is_mul) begin
      y       <= s_y;
      hi      <= '0;
      flags_q <= s_flags;
      err     <= s_err;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (N=8), plus hand-written MUL,
// backpressure, reset-abort and MUL_EN=0 sequences.
module tb_alu_mc;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [N-1:0] a, b, y, hi;
  logic [3:0]   op, flags;

  // Second instance with the multiplier disabled.
  logic         in_valid2, in_ready2, out_valid2, out_ready2, err2;
  logic [N-1:0] a2, b2, y2, hi2;
  logic [3:0]   op2, flags2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mc #(.N(N), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .hi(hi), .flags(flags), .err(err)
  );

  alu_mc #(.N(N), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
    .y(y2), .hi(hi2), .flags(flags2), .err(err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
    logic [3:0]   flags;  // {Z,N,C,V}
    logic         err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // op, a, b -> y, flags, err
    vecs[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0}; // ADD signed overflow
    vecs[1]  = '{4'b0110, 8'h05, 8'h05, 8'h00, 4'b1010, 1'b0}; // SUB equal
    vecs[2]  = '{4'b0011, 8'h80, 8'h7F, 8'h01, 4'b0000, 1'b0}; // SLT with V=1
    vecs[3]  = '{4'b0111, 8'h80, 8'h7F, 8'h00, 4'b1000, 1'b0}; // SLTU
    vecs[4]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0}; // AND
    vecs[5]  = '{4'b0001, 8'hF0, 8'h0F, 8'hFF, 4'b0100, 1'b0}; // OR
    vecs[6]  = '{4'b1000, 8'hAA, 8'hFF, 8'h55, 4'b0000, 1'b0}; // XOR
    vecs[7]  = '{4'b1001, 8'hF0, 8'h0F, 8'h00, 4'b1000, 1'b0}; // NOR
    vecs[8]  = '{4'b0100, 8'hF0, 8'h3C, 8'hC0, 4'b0100, 1'b0}; // ANDN
    vecs[9]  = '{4'b0101, 8'h00, 8'hFF, 8'h00, 4'b1000, 1'b0}; // ORN
    vecs[10] = '{4'b1011, 8'h81, 8'h0B, 8'h08, 4'b0000, 1'b0}; // SLL, amount masked to 3
    vecs[11] = '{4'b1100, 8'h81, 8'h04, 8'h08, 4'b0000, 1'b0}; // SRL
    vecs[12] = '{4'b1101, 8'h80, 8'h03, 8'hF0, 4'b0100, 1'b0}; // SRA sign fill
    vecs[13] = '{4'b0010, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0}; // ADD carry out
    vecs[14] = '{4'b0110, 8'h00, 8'h01, 8'hFF, 4'b0100, 1'b0}; // SUB borrow
    vecs[15] = '{4'b0110, 8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0}; // SUB signed overflow
    vecs[16] = '{4'b0011, 8'h05, 8'h80, 8'h00, 4'b1000, 1'b0}; // SLT 5 < -128 false
    vecs[17] = '{4'b0111, 8'h05, 8'h80, 8'h01, 4'b0000, 1'b0}; // SLTU 5 < 128
    vecs[18] = '{4'b1111, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1}; // illegal
    vecs[19] = '{4'b1110, 8'hFF, 8'hFF, 8'h00, 4'b0000, 1'b1}; // illegal
  end

  int edges;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; op2 = '0; out_ready2 = 1'b1;

    // Reset state
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst y", y, 0);
    check("rst hi", hi, 0);
    check("rst flags", flags, 0);
    check("rst err", err, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 check("rst in_ready", in_ready, 1);

    // Table of single-cycle ops, back to back with out_ready=1
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), out_valid, 1);
      check($sformatf("v%0d y", i), y, vecs[i].y);
      check($sformatf("v%0d hi", i), hi, 0);
      check($sformatf("v%0d flags", i), flags, vecs[i].flags);
      check($sformatf("v%0d err", i), err, vecs[i].err);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1 check("idle out_valid", out_valid, 0);

    // MUL FF*FF, result held by out_ready=0; operands changed after accept
    @(negedge clk);
    in_valid = 1'b1; op = 4'b1010; a = 8'hFF; b = 8'hFF; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 4'b0000;
    edges = 0;
    while (!out_valid && edges < 20) begin
      check($sformatf("mul busy in_ready e%0d", edges), in_ready, 0);
      @(posedge clk); #1;
      edges++;
    end
    check("mul latency edges", edges, 8);
    check("mul out_valid", out_valid, 1);
    check("mul y", y, 8'h01);
    check("mul hi", hi, 8'hFE);
    check("mul flags", flags, 4'b0010);
    check("mul err", err, 0);

    // Backpressure: 5 cycles held
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", i), out_valid, 1);
      check($sformatf("bp%0d y", i), y, 8'h01);
      check($sformatf("bp%0d flags", i), flags, 4'b0010);
      check($sformatf("bp%0d in_ready", i), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 4'b0001; a = 8'hF0; b = 8'h0F;
    #1 check("bp release in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp new out_valid", out_valid, 1);
    check("bp new y", y, 8'hFF);
    check("bp new hi", hi, 8'h00);
    check("bp new flags", flags, 4'b0100);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1 check("bp idle out_valid", out_valid, 0);

    // Reset during BUSY cycle 4 of a MUL
    @(negedge clk);
    in_valid = 1'b1; op = 4'b1010; a = 8'h03; b = 8'h05;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort y", y, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("abort in_ready", in_ready, 1);
    edges = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) edges++;
    end
    check("abort no stale result", edges, 0);

    // MUL_EN=0: MUL encoding is illegal, single-cycle
    @(negedge clk);
    in_valid2 = 1'b1; op2 = 4'b1010; a2 = 8'hFF; b2 = 8'hFF;
    @(posedge clk); #1;
    check("nomul out_valid", out_valid2, 1);
    check("nomul err", err2, 1);
    check("nomul y", y2, 0);
    check("nomul hi", hi2, 0);
    check("nomul flags", flags2, 0);
    @(negedge clk); op2 = 4'b0010; a2 = 8'h01; b2 = 8'h02;
    @(posedge clk); #1;
    check("nomul add y", y2, 8'h03);
    check("nomul add err", err2, 0);
    @(negedge clk); in_valid2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
